hdu_port_arbiter: RTL and testbench

HDU_PORT_ARBITER -- requirements
Module: hdu_port_arbiter

---
 rtl/hdu_port_arbiter.sv | 113 +++++++++++
 tb/tb_hdu_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdu_port_arbiter.sv
// rtl/hdu_port_arbiter.sv - round-robin read-port arbiter in front of a hazard detection unit
// Defining HDU_ARB_STATS_EN adds the stall_cycles and grant_total statistics outputs.
module hdu_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int REQ_NUM_W = 2,
  parameter int OUT_MAX   = 8,
  localparam int REQ_NUM  = 2**REQ_NUM_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_valid,
  input  logic [REQ_NUM*ADDR_W-1:0] req_addr,
  output logic [REQ_NUM-1:0]        req_ready,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_addr,
  output logic [ADDR_W-1:0]         hdu_raddr,
  output logic                      hdu_raddr_valid,
  output logic [ADDR_W-1:0]         hdu_waddr,
  output logic                      hdu_waddr_valid,
  input  logic                      hdu_stall,
  output logic [REQ_NUM_W-1:0]      grant_id,
  output logic [7:0]                outstanding,
  output logic                      err_underflow
`ifdef HDU_ARB_STATS_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               grant_total
`endif
);

  typedef enum logic {ARB, HOLD} state_t;

  localparam logic [7:0] OUT_LIMIT = 8'(OUT_MAX);

  state_t               state, state_next;
  logic [REQ_NUM_W-1:0] rr_ptr;
  logic [REQ_NUM_W-1:0] grant_idx;
  logic [REQ_NUM_W-1:0] cand;
  logic                 xfer;

  // Write-backs bypass the FSM so a pending stall can clear in the same cycle.
  assign hdu_waddr       = wb_addr;
  assign hdu_waddr_valid = wb_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:     if (hdu_stall)  state_next = HOLD;
      HOLD:    if (!hdu_stall) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Rotating priority search starting at rr_ptr; only valid requesters can win.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    cand      = '0;
    xfer      = 1'b0;
    if (!rst && state == ARB && !hdu_stall && outstanding < OUT_LIMIT) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        cand = rr_ptr + REQ_NUM_W'(i);
        if (!xfer && req_valid[cand]) begin
          xfer      = 1'b1;
          grant_idx = cand;
        end
      end
      if (xfer) req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      outstanding     <= '0;
      err_underflow   <= 1'b0;
      hdu_raddr       <= '0;
      hdu_raddr_valid <= 1'b0;
      grant_id        <= '0;
    end else begin
      hdu_raddr_valid <= xfer;
      if (xfer) begin
        rr_ptr    <= grant_idx + 1'b1;
        hdu_raddr <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        grant_id  <= grant_idx;
      end
      if (xfer && !wb_valid) begin
        outstanding <= outstanding + 8'd1;
      end else if (!xfer && wb_valid) begin
        if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
        else                     err_underflow <= 1'b1;
      end
    end
  end

`ifdef HDU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      grant_total  <= '0;
    end else begin
      if (state == HOLD && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (xfer) grant_total <= grant_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdu_port_arbiter.sv
// tb/tb_hdu_port_arbiter.sv - scoreboard bench for hdu_port_arbiter with a reference model
module tb_hdu_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_addr;
  logic [3:0]  req_ready;
  logic        wb_valid;
  logic [15:0] wb_addr;
  logic [15:0] hdu_raddr;
  logic        hdu_raddr_valid;
  logic [15:0] hdu_waddr;
  logic        hdu_waddr_valid;
  logic        hdu_stall;
  logic [1:0]  grant_id;
  logic [7:0]  outstanding;
  logic        err_underflow;
`ifdef HDU_ARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] grant_total;
`endif

  hdu_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .hdu_raddr(hdu_raddr), .hdu_raddr_valid(hdu_raddr_valid),
    .hdu_waddr(hdu_waddr), .hdu_waddr_valid(hdu_waddr_valid), .hdu_stall(hdu_stall),
    .grant_id(grant_id), .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef HDU_ARB_STATS_EN
    , .stall_cycles(stall_cycles), .grant_total(grant_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] addr; logic [1:0] id; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: the arbiter is in HOLD exactly when the previous cycle stalled.
  bit          m_hold = 0;
  int          m_rr   = 0;
  int          m_out  = 0;
  bit          m_err  = 0;
  longint      m_sc   = 0;
  longint      m_gt   = 0;
  logic [3:0]  m_ready;
  int          m_g;
  int          m_k;
  exp_t        m_e;

  always @(negedge clk) begin
    m_ready = '0;
    m_g     = -1;
    if (!rst && !m_hold && !hdu_stall && m_out < 8) begin
      for (int i = 0; i < 4; i++) begin
        m_k = (m_rr + i) % 4;
        if (m_g < 0 && req_valid[m_k]) m_g = m_k;
      end
    end
    if (m_g >= 0) m_ready[m_g] = 1'b1;
    check("req_ready", req_ready, m_ready);
    check("outstanding", outstanding, 64'(m_out));
    check("err_underflow", err_underflow, m_err);
    check("hdu_waddr", hdu_waddr, wb_addr);
    check("hdu_waddr_valid", hdu_waddr_valid, wb_valid);
`ifdef HDU_ARB_STATS_EN
    check("stall_cycles", stall_cycles, m_sc[31:0]);
    check("grant_total", grant_total, m_gt[31:0]);
`endif
    if (m_g >= 0) begin
      m_e.addr = req_addr[m_g*16 +: 16];
      m_e.id   = 2'(m_g);
      exp_q.push_back(m_e);
    end
    if (rst) begin
      m_hold = 0; m_rr = 0; m_out = 0; m_err = 0; m_sc = 0; m_gt = 0;
    end else begin
      if (m_hold && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (m_g >= 0) begin
        m_gt++;
        m_rr = (m_g + 1) % 4;
      end
      if (m_g >= 0 && !wb_valid) m_out++;
      else if (m_g < 0 && wb_valid) begin
        if (m_out > 0) m_out--;
        else m_err = 1;
      end
      m_hold = hdu_stall;
    end
  end

  logic [15:0] last_addr = '0;
  logic [1:0]  last_id   = '0;
  bit          rst_d     = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst_d) begin
      last_addr = '0;
      last_id   = '0;
    end
    if (hdu_raddr_valid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", hdu_raddr_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hdu_raddr", hdu_raddr, mon_e.addr);
        check("grant_id", grant_id, mon_e.id);
        last_addr = mon_e.addr;
        last_id   = mon_e.id;
      end
    end else begin
      check("raddr_hold", hdu_raddr, last_addr);
      check("grant_id_hold", grant_id, last_id);
    end
    rst_d = rst;
  end

  task automatic step(input logic [3:0] v, input logic s, input logic w, input logic r);
    @(posedge clk);
    #1;
    req_valid = v;
    hdu_stall = s;
    wb_valid  = w;
    rst       = r;
    req_addr  = {$urandom, $urandom};
    wb_addr   = 16'($urandom);
  endtask

  task automatic do_reset();
    step(4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; wb_valid = 1'b0; wb_addr = '0; hdu_stall = 1'b0;
    do_reset();
    step(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_outstanding", outstanding, 8'd0);
    check("reset_rvalid", hdu_raddr_valid, 1'b0);

    // Full load with write-back every cycle: strict 0,1,2,3 rotation.
    for (int i = 0; i < 12; i++) step(4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("rotation_rvalid", hdu_raddr_valid, 1'b1);

    // One grant, then a five-cycle stall.
    do_reset();
    step(4'h1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef HDU_ARB_STATS_EN
    check("stall_cycles_5", stall_cycles, 32'd5);
`endif

    // Fill to OUT_MAX, then release a single slot.
    do_reset();
    for (int i = 0; i < 10; i++) step(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_outstanding", outstanding, 8'd8);
    check("full_ready", req_ready, 4'h0);
    step(4'hF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("refill_outstanding", outstanding, 8'd8);

    // Simultaneous transfer and write-back at outstanding 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h1, 1'b0, 1'b1, 1'b0);
    step(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("same_cycle_outstanding", outstanding, 8'd3);

    // Underflow is sticky until reset.
    do_reset();
    step(4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("underflow_sticky", err_underflow, 1'b1);
    do_reset();
    step(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("underflow_cleared", err_underflow, 1'b0);

    // Reset right after a grant to requester 2.
    step(4'h1, 1'b0, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_rvalid", hdu_raddr_valid, 1'b0);
    check("post_reset_grant0", req_ready, 4'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 49) == 0));

    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
